nios_system_led_pwm_0: RTL and testbench

- Avalon-MM write/read output PIO slave for the Nios system; drives board LEDs from CPU register writes.
- Adds per-bank brightness control through a prescaled 8-bit PWM generator with a glitch-free duty update.
- Readback path matches the system's input PIO slaves: readdata is registered, 1-cycle latency, updated every clock from address.

---
 rtl/nios_system_led_pwm_0.sv | 130 +++++++++++++
 tb/tb_nios_system_led_pwm_0.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nios_system_led_pwm_0.sv
// LED output PIO slave with registered readback and an optional prescaled
// 8-bit PWM brightness stage, built when LED_PWM_DUTY_EN is defined.

module nios_system_led_pwm_0_lane (
    input  logic clk,
    input  logic reset,
    input  logic data_i,
    input  logic en_i,
    output logic out_o
);
    logic out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= 1'b0;
        else       out_q <= data_i & en_i;
    end

    assign out_o = out_q;
endmodule

module nios_system_led_pwm_0 #(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PRESCALE    = 195
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      rd_q, rd_d;
    logic             pwm_on;
    logic [7:0]       duty_rd;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                2'd0:    data_d = wdata;
                2'd2:    data_d = data_q | wdata;
                2'd3:    data_d = data_q & ~wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= RESET_VALUE;
        else       data_q <= data_d;
    end

`ifdef LED_PWM_DUTY_EN
    localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      duty_pend_q, duty_pend_d;
    logic [7:0]      duty_act_q, duty_act_d;

    assign tick = (ps_q == PS_LAST);

    // Active duty only moves at the period boundary so a running period is never cut short.
    always_comb begin
        ps_d        = tick ? '0 : ps_q + PS_W'(1);
        cnt_d       = tick ? cnt_q + 8'd1 : cnt_q;
        duty_pend_d = (wr_en && address == 2'd1) ? writedata[7:0] : duty_pend_q;
        duty_act_d  = (tick && cnt_q == 8'hFF) ? duty_pend_q : duty_act_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q        <= '0;
            cnt_q       <= 8'd0;
            duty_pend_q <= 8'hFF;
            duty_act_q  <= 8'hFF;
        end else begin
            ps_q        <= ps_d;
            cnt_q       <= cnt_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
        end
    end

    assign pwm_on  = (duty_act_q == 8'hFF) | (cnt_q < duty_act_q);
    assign duty_rd = duty_pend_q;
`else
    assign pwm_on  = 1'b1;
    assign duty_rd = 8'd0;
`endif

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0:    rd_d = 32'(data_q);
            2'd1:    rd_d = {24'd0, duty_rd};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    assign readdata = rd_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nios_system_led_pwm_0_lane u_lane (
            .clk    (clk),
            .reset  (reset),
            .data_i (data_q[i]),
            .en_i   (pwm_on),
            .out_o  (out_port[i])
        );
    end
endmodule

// File: tb/tb_nios_system_led_pwm_0.sv
// Directed bench for the LED PIO; PWM expectations apply when LED_PWM_DUTY_EN is defined.

module tb_nios_system_led_pwm_0;
    localparam int W = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks = 0;
    int errors = 0;

    nios_system_led_pwm_0 #(.WIDTH(W), .RESET_VALUE('0), .PRESCALE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic count_run(input logic [W-1:0] v, input int maxc, output int n);
        n = 0;
        while (out_port === v && n < maxc) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_out(input logic [W-1:0] v, input int maxc, input string tag);
        int i = 0;
        while (out_port !== v && i < maxc) begin
            i++;
            @(negedge clk);
        end
        chk(tag, 32'(out_port), 32'(v));
    endtask

    initial begin
        logic [31:0] rd;
        int n;

        step(3);
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_rd", readdata, 32'h0);
        reset = 1'b0;

        bus_rd(2'd0, rd); chk("rst_rd0", rd, 32'h0);
        bus_rd(2'd1, rd);
`ifdef LED_PWM_DUTY_EN
        chk("rst_rd1", rd, 32'hFF);
`else
        chk("rst_rd1", rd, 32'h0);
`endif
        bus_rd(2'd2, rd); chk("rst_rd2", rd, 32'h0);
        bus_rd(2'd3, rd); chk("rst_rd3", rd, 32'h0);
        chk("rst_out2", 32'(out_port), 32'h0);

        // Upper writedata bits are dropped; out and readdata lag the write edge by one clock.
        address = 2'd0;
        bus_wr(2'd0, 32'hFFFF_F2A5);
        chk("data_out_lat0", 32'(out_port), 32'h0);
        chk("data_rd_lat0", readdata, 32'h0);
        step(1);
        chk("data_out_lat1", 32'(out_port), 32'h2A5);
        chk("data_rd_lat1", readdata, 32'h2A5);

        bus_wr(2'd0, 32'h00F);
        bus_wr(2'd2, 32'h300);
        bus_rd(2'd0, rd); chk("outset", rd, 32'h30F);
        bus_wr(2'd3, 32'h005);
        bus_rd(2'd0, rd); chk("outclr", rd, 32'h30A);
        chk("outclr_out", 32'(out_port), 32'h30A);
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd3, 32'h0);
        bus_rd(2'd0, rd); chk("set_clr_zero", rd, 32'h30A);
        address = 2'd0; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
        step(1);
        write_n = 1'b1;
        bus_rd(2'd0, rd); chk("cs_low", rd, 32'h30A);
        address = 2'd0; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b1;
        step(1);
        chipselect = 1'b0;
        bus_rd(2'd0, rd); chk("wn_high", rd, 32'h30A);
        bus_rd(2'd2, rd); chk("outset_rd0", rd, 32'h0);
        bus_rd(2'd3, rd); chk("outclr_rd0", rd, 32'h0);

`ifdef LED_PWM_DUTY_EN
        bus_wr(2'd0, 32'h3FF);
        bus_wr(2'd1, 32'hFFFF_FF40);
        bus_rd(2'd1, rd); chk("duty_rd", rd, 32'h40);
        step(600);
        wait_out(10'h000, 600, "d64_sync_off");
        wait_out(10'h3FF, 600, "d64_sync_on");
        count_run(10'h3FF, 2000, n); chk("d64_on", 32'(n), 32'd128);
        count_run(10'h000, 2000, n); chk("d64_off", 32'(n), 32'd384);

        bus_wr(2'd1, 32'h0);
        step(1100);
        count_run(10'h000, 512, n); chk("d0_const", 32'(n), 32'd512);
        bus_wr(2'd1, 32'hFF);
        step(1100);
        count_run(10'h3FF, 512, n); chk("dff_const", 32'(n), 32'd512);

        // Mid-period update: cnt=100 under duty 200, switching to 50.
        bus_wr(2'd1, 32'd200);
        step(1100);
        wait_out(10'h000, 600, "mid_sync_off");
        wait_out(10'h3FF, 600, "mid_sync_on");
        step(199);
        bus_wr(2'd1, 32'd50);
        step(1);
        chk("mid_rd", readdata, 32'd50);
        count_run(10'h3FF, 2000, n); chk("mid_on_rest", 32'(n), 32'd199);
        count_run(10'h000, 2000, n); chk("mid_off", 32'(n), 32'd112);
        count_run(10'h3FF, 2000, n); chk("new_on", 32'(n), 32'd100);
        count_run(10'h000, 2000, n); chk("new_off", 32'(n), 32'd412);

        // Land on pwm_cnt=150 and reset asynchronously.
        step(299);
        chk("pre_rst_rd", readdata, 32'd50);
        #1 reset = 1'b1;
        #1;
        chk("arst_out", 32'(out_port), 32'h0);
        chk("arst_rd", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // Counters restart from 0: DUTY=0 only takes effect after a full 512-clk period.
        bus_wr(2'd0, 32'h3FF);
        bus_wr(2'd1, 32'h0);
        count_run(10'h3FF, 2000, n); chk("post_rst_period", 32'(n), 32'd511);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        bus_rd(2'd1, rd); chk("post_rst_duty", rd, 32'hFF);
        bus_rd(2'd0, rd); chk("post_rst_data", rd, 32'h0);
        chk("post_rst_out", 32'(out_port), 32'h0);
`else
        bus_wr(2'd1, 32'hAB);
        bus_rd(2'd1, rd); chk("duty_absent", rd, 32'h0);
        bus_rd(2'd0, rd); chk("duty_wr_ignored", rd, 32'h30A);
        step(600);
        count_run(10'h30A, 512, n); chk("out_const", 32'(n), 32'd512);
        bus_wr(2'd0, 32'h3FF);
        step(1);
        chk("pre_rst_out", 32'(out_port), 32'h3FF);
        #1 reset = 1'b1;
        #1;
        chk("arst_out", 32'(out_port), 32'h0);
        chk("arst_rd", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(2'd0, rd); chk("post_rst_data", rd, 32'h0);
        chk("post_rst_out", 32'(out_port), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
